fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction fetch queue between the instruction-memory response path and the first pipeline stage register (ID).
- Buffers up to DEPTH fetched {pc, inst} records.
- Presents the oldest record downstream using the valid/allow interlock: downstream allow_out feeds our allow_in.
- Absorbs memory responses that arrive while decode is stalled.
- Supports a single-cycle flush for branch/exception redirect.

Parameters:
- T, IF_DATA (cpuDefine): record type carried per entry ({pc, inst, excp bits}).
- DEPTH, 4: number of entries. Must be a power of two, ≥2.
- PTR_W, $clog2(DEPTH): pointer width. Derived; do not override.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch response valid
- in_data  in  T  fetch response record
- in_ready  out  1  queue can accept in_data this cycle
- valid_out  out  1  head record valid toward ID stage
- data_out  out  T  head record, or nop_data when empty
- nop_data  in  T  bubble record driven when empty
- allow_in  in  1  downstream stage accepts this cycle
- flush  in  1  discard all entries (redirect)
- count  out  PTR_W+1  current occupancy

Behaviour:
- State
  - wr_ptr, rd_ptr: PTR_W bits, wrap modulo DEPTH naturally.
  - count: PTR_W+1 bits.
  - Storage: flop array, not reset.
- Reset (aresetn=0 at posedge): wr_ptr=0, rd_ptr=0, count=0.
  - While aresetn=0, in_ready=0 and valid_out=0, combinationally.
- Handshakes, with push = in_valid && in_ready and pop = valid_out && allow_in:
  - in_ready = aresetn && !flush && (count != DEPTH). There is no full-plus-pop pass-through; in_ready does not depend on allow_in.
  - valid_out = aresetn && !flush && (count != 0).
  - data_out = mem[rd_ptr] when count != 0, else nop_data. data_out must not be X when empty.
- Per cycle at posedge:
  - push: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1.
  - pop: rd_ptr <= rd_ptr+1.
  - count <= count + push - pop. Simultaneous push and pop leaves count unchanged, including at count=DEPTH-1 and count=1.
- Latency: a record pushed in cycle N is visible on valid_out/data_out in cycle N+1. There is no empty bypass.
- Flush (synchronous, priority below reset, above push/pop):
  - At the posedge with flush=1: wr_ptr <= 0, rd_ptr <= 0, count <= 0.
  - A concurrent in_valid is dropped; in_ready=0 already signals no acceptance.
  - valid_out=0 during the flush cycle, so nothing is popped.
  - The cycle after flush: empty; in_ready=1.
- Full (count=DEPTH): in_ready=0. Data held stable; in_data ignored.
- Empty (count=0): valid_out=0; data_out=nop_data; allow_in ignored.
- Back-pressure: while allow_in=0, data_out and valid_out hold stable. This matches what the downstream stage register requires.
- Wrap-around: pointers roll DEPTH-1 → 0 with no special case. Full and empty are distinguished by count only.
- Assertions for the bench: count ≤ DEPTH; no push when count=DEPTH; no pop when count=0.

Decomposition:
- cpuDefine package holds:
  - IF_DATA typedef {pc[31:0], inst[31:0], excp_valid, excp_code[5:0]}.
  - Constant FQ_DEPTH=4.
  - IF_NOP constant: inst = NOP encoding, pc=0, excp_valid=0.
- Single module. No sub-module is warranted: pointer and count logic are a few lines each.

Test Plan:
- Reset then idle: aresetn=0 for 2 cycles, then 1 → count=0, valid_out=0, data_out=IF_NOP, in_ready=1 from the first cycle after release.
- Fill: push pc=0x1c000000,+4,+8,+C with allow_in=0 → count=4, in_ready=0. A 5th in_valid is not accepted. data_out.pc stays 0x1c000000.
- Drain: allow_in=1 from full → pcs 0x1c000000..0x1c00000C appear in order, one per cycle. Then valid_out=0, data_out=IF_NOP.
- Simultaneous push/pop: count=2, in_valid=1, allow_in=1 for 10 cycles → count stays 2, order preserved. Pointers wrap at least twice.
- Flush: count=3 with in_valid=1 and flush=1 for one cycle → next cycle count=0, valid_out=0. The flush-cycle record never appears. The next push, pc=0x1c000100, is the first output.
- Reset mid-operation: count=3, aresetn=0 for one cycle while in_valid=1 → count=0, the dropped record never appears, in_ready=0 during reset.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types: the IF->ID record, the queue depth and the bubble record.
package cpuDefine;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp_valid;
    logic [5:0]  excp_code;
  } IF_DATA;

  localparam int FQ_DEPTH = 4;

  // LA32 nop: andi r0, r0, 0
  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  localparam IF_DATA IF_NOP = '{pc: 32'h0, inst: NOP_INST, excp_valid: 1'b0, excp_code: 6'h0};

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers fetch responses and presents the oldest record
// to the ID stage through the valid/allow interlock, with a one-cycle redirect flush.
module fetch_queue
  import cpuDefine::*;
#(
  parameter type T = IF_DATA,
  parameter int DEPTH = FQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           in_valid,
  input  T               in_data,
  output logic           in_ready,
  output logic           valid_out,
  output T               data_out,
  input  T               nop_data,
  input  logic           allow_in,
  input  logic           flush,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  T                 mem [DEPTH];

  logic push;
  logic pop;

  // Full/empty are told apart by count alone; pointers simply wrap.
  assign in_ready  = aresetn && !flush && (count_reg != FULL_COUNT);
  assign valid_out = aresetn && !flush && (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = valid_out && allow_in;
  assign data_out  = (count_reg != '0) ? mem[rd_ptr_reg] : nop_data;
  assign count     = count_reg;

  assign count_next = count_reg + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Storage is not reset; push is already masked by reset and flush through in_ready.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge aclk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) mem[gi] <= in_data;
      end
    end
  endgenerate

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for reset/fill/drain/flush,
// plus hand-written streaming and mid-operation reset sequences.
module tb_fetch_queue;
  import cpuDefine::*;

  localparam logic [31:0] B = 32'h1c00_0000;

  logic       aclk;
  logic       aresetn;
  logic       in_valid;
  IF_DATA     in_data;
  logic       in_ready;
  logic       valid_out;
  IF_DATA     data_out;
  IF_DATA     nop_data;
  logic       allow_in;
  logic       flush;
  logic [2:0] count;

  int compared   = 0;
  int mismatched = 0;

  fetch_queue dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .nop_data  (nop_data),
    .allow_in  (allow_in),
    .flush     (flush),
    .count     (count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic IF_DATA mk_rec(input logic [31:0] pc);
    IF_DATA r;
    r.pc         = pc;
    r.inst       = pc ^ 32'hA5A5_0000;
    r.excp_valid = pc[2];
    r.excp_code  = pc[7:2];
    return r;
  endfunction

  task automatic chk(input string name, input logic [70:0] got, input logic [70:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply inputs for one cycle and wait for the sampling point.
  task automatic cyc(input logic rst_n, input logic iv, input logic [31:0] pc,
                     input logic al, input logic fl);
    aresetn  = rst_n;
    in_valid = iv;
    in_data  = mk_rec(pc);
    allow_in = al;
    flush    = fl;
    @(negedge aclk);
  endtask

  task automatic adv();
    @(posedge aclk);
    #1;
  endtask

  // Structural invariants checked every cycle out of reset.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && !$isunknown(count)) begin
      compared++;
      if (count > 3'd4 || (count == 3'd4 && in_ready) || (count == 3'd0 && valid_out)) begin
        mismatched++;
        $display("FAIL invariant: count=%0d in_ready=%0b valid_out=%0b", count, in_ready, valid_out);
      end
    end
  end

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [31:0] pc;
    logic        al;
    logic        fl;
    logic        chk_state;
    logic        exp_valid;
    logic        exp_ready;
    logic [2:0]  exp_count;
    logic        exp_nop;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[21];

  initial begin
    nop_data = IF_NOP;
    //            rst iv  pc           al  fl  chk v   rdy cnt   nop exp_pc
    vecs[0]  = '{1'b0,1'b0,32'h0,     1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,32'h0};
    vecs[1]  = '{1'b0,1'b0,32'h0,     1'b0,1'b0,1'b1,1'b0,1'b0,3'd0,1'b1,32'h0};
    vecs[2]  = '{1'b1,1'b1,B,         1'b0,1'b0,1'b1,1'b0,1'b1,3'd0,1'b1,32'h0};
    vecs[3]  = '{1'b1,1'b1,B+32'h4,   1'b0,1'b0,1'b1,1'b1,1'b1,3'd1,1'b0,B};
    vecs[4]  = '{1'b1,1'b1,B+32'h8,   1'b0,1'b0,1'b1,1'b1,1'b1,3'd2,1'b0,B};
    vecs[5]  = '{1'b1,1'b1,B+32'hC,   1'b0,1'b0,1'b1,1'b1,1'b1,3'd3,1'b0,B};
    vecs[6]  = '{1'b1,1'b1,B+32'h10,  1'b0,1'b0,1'b1,1'b1,1'b0,3'd4,1'b0,B};
    vecs[7]  = '{1'b1,1'b1,B+32'h10,  1'b0,1'b0,1'b1,1'b1,1'b0,3'd4,1'b0,B};
    vecs[8]  = '{1'b1,1'b0,32'h0,     1'b1,1'b0,1'b1,1'b1,1'b0,3'd4,1'b0,B};
    vecs[9]  = '{1'b1,1'b0,32'h0,     1'b1,1'b0,1'b1,1'b1,1'b1,3'd3,1'b0,B+32'h4};
    vecs[10] = '{1'b1,1'b0,32'h0,     1'b1,1'b0,1'b1,1'b1,1'b1,3'd2,1'b0,B+32'h8};
    vecs[11] = '{1'b1,1'b0,32'h0,     1'b1,1'b0,1'b1,1'b1,1'b1,3'd1,1'b0,B+32'hC};
    vecs[12] = '{1'b1,1'b0,32'h0,     1'b1,1'b0,1'b1,1'b0,1'b1,3'd0,1'b1,32'h0};
    vecs[13] = '{1'b1,1'b1,B+32'h20,  1'b0,1'b0,1'b1,1'b0,1'b1,3'd0,1'b1,32'h0};
    vecs[14] = '{1'b1,1'b1,B+32'h24,  1'b0,1'b0,1'b1,1'b1,1'b1,3'd1,1'b0,B+32'h20};
    vecs[15] = '{1'b1,1'b1,B+32'h28,  1'b0,1'b0,1'b1,1'b1,1'b1,3'd2,1'b0,B+32'h20};
    vecs[16] = '{1'b1,1'b1,B+32'h2C,  1'b1,1'b1,1'b1,1'b0,1'b0,3'd3,1'b0,B+32'h20};
    vecs[17] = '{1'b1,1'b1,B+32'h100, 1'b1,1'b0,1'b1,1'b0,1'b1,3'd0,1'b1,32'h0};
    vecs[18] = '{1'b1,1'b0,32'h0,     1'b1,1'b0,1'b1,1'b1,1'b1,3'd1,1'b0,B+32'h100};
    vecs[19] = '{1'b1,1'b0,32'h0,     1'b1,1'b0,1'b1,1'b0,1'b1,3'd0,1'b1,32'h0};
    vecs[20] = '{1'b1,1'b0,32'h0,     1'b1,1'b0,1'b1,1'b0,1'b1,3'd0,1'b1,32'h0};

    for (int i = 0; i < 21; i++) begin
      cyc(vecs[i].rst_n, vecs[i].iv, vecs[i].pc, vecs[i].al, vecs[i].fl);
      $display("row %0d: count=%0d valid_out=%0b in_ready=%0b pc=%h",
               i, count, valid_out, in_ready, data_out.pc);
      chk($sformatf("row%0d valid_out", i), 71'(valid_out), 71'(vecs[i].exp_valid));
      chk($sformatf("row%0d in_ready", i), 71'(in_ready), 71'(vecs[i].exp_ready));
      if (vecs[i].chk_state) begin
        chk($sformatf("row%0d count", i), 71'(count), 71'(vecs[i].exp_count));
        chk($sformatf("row%0d data_out", i), data_out,
            vecs[i].exp_nop ? IF_NOP : mk_rec(vecs[i].exp_pc));
      end
      adv();
    end

    // Streaming: fill to 2, then push and pop together so pointers wrap repeatedly.
    cyc(1'b1, 1'b1, B + 32'h200, 1'b0, 1'b0); adv();
    cyc(1'b1, 1'b1, B + 32'h204, 1'b0, 1'b0); adv();
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b1, B + 32'h208 + 32'(4 * k), 1'b1, 1'b0);
      $display("stream %0d: count=%0d pc=%h", k, count, data_out.pc);
      chk($sformatf("stream%0d count", k), 71'(count), 71'(3'd2));
      chk($sformatf("stream%0d valid_out", k), 71'(valid_out), 71'(1'b1));
      chk($sformatf("stream%0d data_out", k), data_out, mk_rec(B + 32'h200 + 32'(4 * k)));
      adv();
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      $display("tail %0d: count=%0d pc=%h", k, count, data_out.pc);
      chk($sformatf("tail%0d data_out", k), data_out, mk_rec(B + 32'h228 + 32'(4 * k)));
      adv();
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    $display("drained: count=%0d valid_out=%0b", count, valid_out);
    chk("drained count", 71'(count), 71'(3'd0));
    chk("drained data_out", data_out, IF_NOP);
    adv();

    // Reset in the middle of operation with a record on the input.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, B + 32'h300 + 32'(4 * k), 1'b0, 1'b0); adv();
    end
    cyc(1'b0, 1'b1, B + 32'h30C, 1'b0, 1'b0);
    $display("midrst: count=%0d in_ready=%0b valid_out=%0b", count, in_ready, valid_out);
    chk("midrst count before", 71'(count), 71'(3'd3));
    chk("midrst in_ready", 71'(in_ready), 71'(1'b0));
    chk("midrst valid_out", 71'(valid_out), 71'(1'b0));
    adv();
    cyc(1'b1, 1'b1, B + 32'h400, 1'b1, 1'b0);
    $display("postrst: count=%0d in_ready=%0b valid_out=%0b", count, in_ready, valid_out);
    chk("postrst count", 71'(count), 71'(3'd0));
    chk("postrst valid_out", 71'(valid_out), 71'(1'b0));
    chk("postrst data_out", data_out, IF_NOP);
    adv();
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    $display("postrst first: count=%0d pc=%h", count, data_out.pc);
    chk("postrst first data_out", data_out, mk_rec(B + 32'h400));
    chk("postrst first count", 71'(count), 71'(3'd1));
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
